// File: rtl/clken_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// width helpers, reset-divisor calculation and the per-channel control record.
package clken_pkg;

  localparam int MAX_NCH = 16;
  localparam int MIN_DIV = 1;

  typedef struct packed {
    logic en;
    logic pend;
    logic flag;
    logic tgl;
  } chan_ctrl_t;

  localparam chan_ctrl_t CTRL_IDLE = '{en: 1'b0, pend: 1'b0, flag: 1'b0, tgl: 1'b0};

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // A single channel still needs a one-bit select port.
  function automatic int chan_width(input int unsigned nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

  // Zero target rate yields zero, which the top-level range check rejects.
  function automatic longint unsigned calc_def_div(input longint unsigned sys_freq,
                                                   input longint unsigned tgt_freq);
    return (tgt_freq == 0) ? 64'd0 : sys_freq / tgt_freq;
  endfunction

  localparam int MAX_CW = chan_width(MAX_NCH);

endpackage

// File: rtl/clken_chan.sv
// One clock-enable channel: wrap counter, shadow divisor applied at wrap,
// registered one-cycle flag and half-rate toggle.
module clken_chan
  import clken_pkg::*;
#(
  parameter int         W       = 16,
  parameter logic [W-1:0] DEF_DIV = W'(10),
  parameter logic       RST_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic         wr_en,
  input  logic         sync,
  output logic         flag,
  output logic         tgl,
  output logic         active,
  output logic         pend
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] div_act;
  logic [W-1:0] div_act_nxt;
  logic [W-1:0] div_pend;
  logic [W-1:0] div_pend_nxt;
  chan_ctrl_t   st;
  chan_ctrl_t   st_nxt;
  logic         wrap;
  logic         wr_off;

  // div_act is never zero while enabled, so the subtraction cannot underflow.
  assign wrap   = st.en && (cnt == div_act - 1'b1);
  assign wr_off = !wr_en || (wr_div == '0);

  always_comb begin
    cnt_nxt      = cnt;
    div_act_nxt  = div_act;
    div_pend_nxt = div_pend;
    st_nxt       = st;

    if (st.en) begin
      if (wrap) begin
        cnt_nxt     = '0;
        st_nxt.flag = 1'b1;
        st_nxt.tgl  = ~st.tgl;
        if (st.pend) begin
          div_act_nxt = div_pend;
          st_nxt.pend = 1'b0;
        end
      end else begin
        cnt_nxt     = cnt + 1'b1;
        st_nxt.flag = 1'b0;
      end
    end

    // A write lands after the wrap bookkeeping so it can re-arm pend on a wrap edge.
    if (wr) begin
      if (wr_off) begin
        cnt_nxt = '0;
        st_nxt  = CTRL_IDLE;
      end else if (!st.en) begin
        div_act_nxt = wr_div;
        cnt_nxt     = '0;
        st_nxt.en   = 1'b1;
        st_nxt.flag = 1'b0;
        st_nxt.tgl  = 1'b0;
      end else begin
        div_pend_nxt = wr_div;
        st_nxt.pend  = 1'b1;
      end
    end

    if (sync && st_nxt.en) begin
      cnt_nxt     = '0;
      st_nxt.flag = 1'b0;
      st_nxt.tgl  = 1'b0;
      if (st_nxt.pend) begin
        div_act_nxt = div_pend_nxt;
        st_nxt.pend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= DEF_DIV;
      div_pend <= DEF_DIV;
      st       <= '{en: RST_EN, pend: 1'b0, flag: 1'b0, tgl: 1'b0};
    end else begin
      cnt      <= cnt_nxt;
      div_act  <= div_act_nxt;
      div_pend <= div_pend_nxt;
      st       <= st_nxt;
    end
  end

  assign flag   = st.flag;
  assign tgl    = st.tgl;
  assign active = st.en;
  assign pend   = st.pend;

endmodule

// File: rtl/clken_mc.sv
// Multi-channel clock-enable generator: decodes config writes to channels,
// fans out the global phase restart and checks the elaboration parameters.
module clken_mc
  import clken_pkg::*;
#(
  parameter int              NCH             = 4,
  parameter int              W               = 16,
  parameter int unsigned     SYS_CLK_FREQ    = 100_000_000,
  parameter int unsigned     TARGET_CLK_FREQ = 10_000_000,
  parameter logic [NCH-1:0]  RST_EN          = '1,
  localparam int             CW              = chan_width(NCH)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic           cfg_en,
  input  logic           sync_rst,
  output logic [NCH-1:0] clk_flag,
  output logic [NCH-1:0] tgl_out,
  output logic [NCH-1:0] ch_active,
  output logic [NCH-1:0] cfg_pend
);

  localparam longint unsigned DEF_DIV_L = calc_def_div(64'(SYS_CLK_FREQ), 64'(TARGET_CLK_FREQ));
  localparam logic [W-1:0]    DEF_DIV   = W'(DEF_DIV_L);

  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("clken_mc: NCH must be within 1..16");
  end

  if (DEF_DIV_L < 64'(MIN_DIV) || DEF_DIV_L >= (64'd1 << W)) begin : g_bad_div
    $error("clken_mc: SYS_CLK_FREQ/TARGET_CLK_FREQ does not fit a W-bit divisor");
  end

  // Channel indices at or above NCH match no instance, so such writes vanish.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (cfg_ch == CW'(i));

    clken_chan #(
      .W      (W),
      .DEF_DIV(DEF_DIV),
      .RST_EN (RST_EN[i])
    ) u_chan (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .wr    (wr),
      .wr_div(cfg_div),
      .wr_en (cfg_en),
      .sync  (sync_rst),
      .flag  (clk_flag[i]),
      .tgl   (tgl_out[i]),
      .active(ch_active[i]),
      .pend  (cfg_pend[i])
    );
  end

endmodule
